mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the node's 256-byte scratch memory. Shares the memory between the sensor sample logger (port 0) and the radio packet engine (port 1) with round-robin fairness. Owns the memory's address, read/write strobes and the bidirectional data bus, and returns read data with a one-cycle acknowledge. Adds a timeout so a stalled read can never hang either requester.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_rr.sv | 21 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port scratch memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    ACK  = 2'd3
  } arb_state_t;

  localparam int NUM_PORTS   = 2;
  localparam int GNT_W       = $clog2(NUM_PORTS);
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 4;   // read timeout counter width

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// port that was not served last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic             req0,
  input  logic             req1,
  input  logic             last,    // 1 = port 1 served last
  output logic [GNT_W-1:0] gnt,
  output logic             valid
);

  // Pure combinational pick
  always_comb begin
    valid = req0 | req1;
    gnt   = '0;
    if (req0 && req1) gnt = GNT_W'(~last);
    else if (req1)    gnt = GNT_W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the 256-byte scratch memory. Grants one
// port at a time, drives the memory strobes and data bus, and returns a
// one-cycle ack. A read that never sees mem_ready is cut off with err=1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF   // legal 2..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic              mem_ready
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  arb_state_t                 state_q, state_d;
  logic [GNT_W-1:0]           gnt_q, gnt_d, rr_gnt;
  logic                       last_q, last_d, rr_valid;
  logic                       drv_q, drv_d, wr_d, rd_d;
  logic [ADDR_W-1:0]          addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d, rdata_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [NUM_PORTS-1:0]       ack_q, ack_d, err_q, err_d;
  req_t [NUM_PORTS-1:0]       port_req;
  req_t                       sel;

  assign port_req[0] = '{we: we0, addr: addr0, wdata: wdata0};
  assign port_req[1] = '{we: we1, addr: addr1, wdata: wdata1};
  assign sel         = port_req[rr_gnt];
  assign cnt_inc     = cnt_q + CNT_W'(1);

  assign ack0 = ack_q[0];
  assign ack1 = ack_q[1];
  assign err0 = err_q[0];
  assign err1 = err_q[1];

  // Bus is ours only during the write cycle
  assign mem_data = drv_q ? wdata_q : {DATA_W{1'bz}};

  mem_arb_rr u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = mem_addr;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata;
    ack_d   = '0;
    err_d   = '0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    drv_d   = 1'b0;
    case (state_q)
      IDLE: if (rr_valid) begin
        gnt_d   = rr_gnt;
        addr_d  = sel.addr;
        wdata_d = sel.wdata;
        cnt_d   = '0;
        if (sel.we) begin
          state_d = WR;
          wr_d    = 1'b1;
          drv_d   = 1'b1;
        end else begin
          state_d = RD;
          rd_d    = 1'b1;
        end
      end
      WR: begin
        state_d      = ACK;
        ack_d[gnt_q] = 1'b1;
      end
      RD: begin
        if (mem_ready) begin
          rdata_d      = mem_data;
          ack_d[gnt_q] = 1'b1;
          state_d      = ACK;
        end else if (cnt_inc == TO_CNT) begin
          // Stalled memory: complete with an error so the port moves on
          rdata_d      = '0;
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          state_d      = ACK;
        end else begin
          cnt_d = cnt_inc;
          rd_d  = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        last_d  = (gnt_q != '0);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= 1'b1;   // port 0 wins the first tie
      mem_addr  <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      drv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      mem_addr  <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata     <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      mem_write <= wr_d;
      mem_read  <= rd_d;
      drv_q     <= drv_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small one-wait-state memory model.
module tb_mem_arbiter;

  localparam int         TO       = 15;
  localparam logic [7:0] BUS_IDLE = 8'hFF;   // pulled-up bus when nobody drives

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata, mem_addr;
  tri1  [7:0] mem_data;
  logic       mem_write, mem_read, mem_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_ready(mem_ready)
  );

  // Memory model: ready one cycle after mem_read is first seen
  logic [7:0] mem [256];
  logic [7:0] mem_q;
  logic       ready_r = 1'b0;
  logic       tie_low;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data;
    mem_q   <= mem[mem_addr];
    ready_r <= mem_read && !ready_r && !tie_low;
  end
  assign mem_ready = ready_r;
  assign mem_data  = (ready_r && mem_read) ? mem_q : 8'hzz;

  // One transaction, called right after a negedge with the DUT idle.
  // lat counts negedges from the request; returns one cycle after ack.
  task automatic run_txn(input int port, input logic we, input logic [7:0] a,
                         input logic [7:0] d, output int lat,
                         output logic [7:0] rd, output logic e, output int nwr,
                         output logic [7:0] wd, output logic [7:0] wa,
                         output int badbus, output int ovl);
    bit got = 0;
    lat = -1; rd = '0; e = 1'b0; nwr = 0; wd = '0; wa = '0; badbus = 0; ovl = 0;
    if (port == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else           begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (mem_write) begin nwr++; wd = mem_data; wa = mem_addr; end
      if (mem_write && mem_read) ovl++;
      if (mem_read && !mem_ready && mem_data !== BUS_IDLE) badbus++;
      if ((port == 0) ? ack0 : ack1) begin
        got = 1; lat = c; rd = rdata; e = (port == 0) ? err0 : err1;
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    got = {ack0, ack1, err0, err1, mem_write, mem_read, 2'b00, rdata};
    exp = 16'h0000;
    vectors++; if (got !== exp) begin miscompares++;
      $display("FAIL reset_ctrl got %h want %h", got, exp); end
    vectors++; if (mem_addr !== 8'h00) begin miscompares++;
      $display("FAIL reset_addr got %h want 00", mem_addr); end
    vectors++; if (mem_data !== BUS_IDLE) begin miscompares++;
      $display("FAIL reset_bus got %h want %h", mem_data, BUS_IDLE); end
  endtask

  task automatic test_write_read();
    int lat, nwr, bb, ov; logic [7:0] rd, wd, wa; logic e;
    run_txn(0, 1'b1, 8'h10, 8'hA5, lat, rd, e, nwr, wd, wa, bb, ov);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_lat got %0d want 2", lat); end
    vectors++; if (nwr !== 1) begin miscompares++; $display("FAIL wr_strobe got %0d want 1", nwr); end
    vectors++; if (wd !== 8'hA5 || wa !== 8'h10) begin miscompares++;
      $display("FAIL wr_bus got %h@%h want a5@10", wd, wa); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL wr_err got %b want 0", e); end
    vectors++; if (mem[8'h10] !== 8'hA5) begin miscompares++;
      $display("FAIL wr_mem got %h want a5", mem[8'h10]); end
    run_txn(0, 1'b0, 8'h10, 8'h00, lat, rd, e, nwr, wd, wa, bb, ov);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rd_lat got %0d want 3", lat); end
    vectors++; if (rd !== 8'hA5) begin miscompares++; $display("FAIL rd_data got %h want a5", rd); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL rd_err got %b want 0", e); end
    vectors++; if (bb !== 0 || ov !== 0) begin miscompares++;
      $display("FAIL rd_bus got badbus=%0d ovl=%0d want 0/0", bb, ov); end
  endtask

  task automatic test_tie();
    int lat, nwr, bb, ov, t0, t1, ovl; logic [7:0] rd, wd, wa, r0; logic e, e0;
    run_txn(1, 1'b1, 8'h20, 8'h5A, lat, rd, e, nwr, wd, wa, bb, ov);
    do_reset();
    t0 = -1; t1 = -1; ovl = 0; r0 = '0; e0 = 1'b1;
    we0 = 1'b0; addr0 = 8'h20; req0 = 1'b1;
    we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'h3C; req1 = 1'b1;
    for (int c = 1; c <= 30 && (t0 < 0 || t1 < 0); c++) begin
      @(negedge clk);
      if (mem_write && mem_read) ovl++;
      if (ack0) begin t0 = c; r0 = rdata; e0 = err0; req0 = 1'b0; end
      if (ack1) begin t1 = c; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    // read granted at edge 1 acks at 3; the write follows grant at edge 5
    vectors++; if (t0 !== 3) begin miscompares++; $display("FAIL tie_ack0 got %0d want 3", t0); end
    vectors++; if (t1 !== 6) begin miscompares++; $display("FAIL tie_ack1 got %0d want 6", t1); end
    vectors++; if (r0 !== 8'h5A || e0 !== 1'b0) begin miscompares++;
      $display("FAIL tie_rdata got %h/%b want 5a/0", r0, e0); end
    vectors++; if (mem[8'h21] !== 8'h3C) begin miscompares++;
      $display("FAIL tie_mem got %h want 3c", mem[8'h21]); end
    vectors++; if (ovl !== 0) begin miscompares++; $display("FAIL tie_overlap got %0d want 0", ovl); end
  endtask

  task automatic test_alternate();
    int n = 0, longp = 0, both = 0;
    int seq [8]; int tim [8];
    logic p0 = 1'b0, p1 = 1'b0;
    do_reset();
    we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h10; req0 = 1'b1;
    we1 = 1'b1; addr1 = 8'h80; wdata1 = 8'h90; req1 = 1'b1;
    for (int c = 1; c <= 60 && n < 8; c++) begin
      @(negedge clk);
      if (ack0 && ack1) both++;
      if ((ack0 && p0) || (ack1 && p1)) longp++;
      p0 = ack0; p1 = ack1;
      if (ack0 && n < 8) begin seq[n] = 0; tim[n] = c; n++; addr0 = addr0 + 8'd1; wdata0 = wdata0 + 8'd1; end
      if (ack1 && n < 8) begin seq[n] = 1; tim[n] = c; n++; addr1 = addr1 + 8'd1; wdata1 = wdata1 + 8'd1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL alt_count got %0d want 8", n); end
    for (int i = 0; i < n; i++) begin
      vectors++; if (seq[i] !== i % 2) begin miscompares++;
        $display("FAIL alt_order[%0d] got %0d want %0d", i, seq[i], i % 2); end
      if (i > 0) begin
        vectors++; if (tim[i] - tim[i-1] !== 3) begin miscompares++;
          $display("FAIL alt_spacing[%0d] got %0d want 3", i, tim[i] - tim[i-1]); end
      end
    end
    vectors++; if (longp !== 0 || both !== 0) begin miscompares++;
      $display("FAIL alt_pulse got long=%0d both=%0d want 0/0", longp, both); end
    vectors++; if (mem[8'h43] !== 8'h13 || mem[8'h83] !== 8'h93) begin miscompares++;
      $display("FAIL alt_mem got %h/%h want 13/93", mem[8'h43], mem[8'h83]); end
  endtask

  task automatic test_timeout();
    int lat, nwr, bb, ov; logic [7:0] rd, wd, wa; logic e;
    run_txn(1, 1'b0, 8'h10, 8'h00, lat, rd, e, nwr, wd, wa, bb, ov);
    vectors++; if (rd !== 8'hA5) begin miscompares++; $display("FAIL to_pre got %h want a5", rd); end
    tie_low = 1'b1;
    run_txn(1, 1'b0, 8'h30, 8'h00, lat, rd, e, nwr, wd, wa, bb, ov);
    vectors++; if (lat !== TO + 1) begin miscompares++; $display("FAIL to_lat got %0d want %0d", lat, TO + 1); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL to_err got %b want 1", e); end
    vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL to_rdata got %h want 00", rd); end
    vectors++; if (bb !== 0) begin miscompares++; $display("FAIL to_bus got %0d want 0", bb); end
    tie_low = 1'b0;
    run_txn(1, 1'b0, 8'h21, 8'h00, lat, rd, e, nwr, wd, wa, bb, ov);
    vectors++; if (lat !== 3 || rd !== 8'h3C || e !== 1'b0) begin miscompares++;
      $display("FAIL to_after got %0d/%h/%b want 3/3c/0", lat, rd, e); end
  endtask

  task automatic test_reset_mid();
    int lat, nwr, bb, ov, nack = 0; logic [7:0] rd, wd, wa; logic e;
    run_txn(0, 1'b0, 8'h10, 8'h00, lat, rd, e, nwr, wd, wa, bb, ov);
    tie_low = 1'b1;
    we0 = 1'b0; addr0 = 8'h10; req0 = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (mem_read !== 1'b1 || rdata !== 8'hA5) begin miscompares++;
      $display("FAIL mid_pre got rd=%b data=%h want 1/a5", mem_read, rdata); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({mem_read, ack0, ack1} !== 3'b000) begin miscompares++;
      $display("FAIL mid_strobes got %b want 000", {mem_read, ack0, ack1}); end
    vectors++; if (rdata !== 8'h00 || mem_addr !== 8'h00) begin miscompares++;
      $display("FAIL mid_regs got %h/%h want 00/00", rdata, mem_addr); end
    vectors++; if (mem_data !== BUS_IDLE) begin miscompares++;
      $display("FAIL mid_bus got %h want %h", mem_data, BUS_IDLE); end
    req0 = 1'b0;
    @(negedge clk); rst_n = 1'b1; tie_low = 1'b0;
    repeat (20) begin @(negedge clk); if (ack0 || ack1 || mem_read) nack++; end
    vectors++; if (nack !== 0) begin miscompares++; $display("FAIL mid_noack got %0d want 0", nack); end
  endtask

  task automatic test_back_to_back();
    int lat, nwr, bb, ov, bbs = 0, ovs = 0; logic [7:0] rd, wd, wa; logic e;
    for (int i = 0; i < 256; i++) begin
      run_txn(1, 1'b1, 8'(i), 8'(i), lat, rd, e, nwr, wd, wa, bb, ov);
      vectors++; if (lat !== 2 || wd !== 8'(i) || wa !== 8'(i)) begin miscompares++;
        $display("FAIL b2b_wr[%0d] got lat=%0d %h@%h", i, lat, wd, wa); end
      bbs += bb; ovs += ov;
    end
    for (int i = 0; i < 256; i++) begin
      run_txn(1, 1'b0, 8'(i), 8'h00, lat, rd, e, nwr, wd, wa, bb, ov);
      vectors++; if (rd !== 8'(i) || e !== 1'b0 || lat !== 3) begin miscompares++;
        $display("FAIL b2b_rd[%0d] got %h err=%b lat=%0d want %h/0/3", i, rd, e, lat, 8'(i)); end
      bbs += bb; ovs += ov;
    end
    vectors++; if (bbs !== 0 || ovs !== 0) begin miscompares++;
      $display("FAIL b2b_bus got badbus=%0d ovl=%0d want 0/0", bbs, ovs); end
  endtask

  initial begin
    rst_n = 1'b0; tie_low = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_write_read();
    test_tie();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
